// File: rtl/power_detect.sv
// power_detect: dwell-qualified threshold detector with hysteresis.
// Consumes the integrated-power stream, raises a level detect while an event
// is in progress, pulses on onset/release, and reports each event's peak
// power and duration (in integrator results) when it releases.
module power_detect #(
   parameter logic [7:0] BASE = 8'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [31:0] power_in,
   input  logic        strobe_in,
   output logic        detect,
   output logic        rise_stb,
   output logic        fall_stb,
   output logic        event_stb,
   output logic [31:0] event_peak,
   output logic [31:0] event_duration,
   output logic [63:0] debug
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      ACTIVE = 2'd2,
      DISARM = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] thr_hi;
      logic [31:0] thr_lo;
      logic [15:0] dwell;
      logic        enable;
   } cfg_t;

   cfg_t        cfg;
   state_t      state;
   logic [15:0] cnt;
   logic [31:0] peak;
   logic [31:0] dur;

   logic [15:0] dwell_eff;
   logic        dwell_one;
   logic        above;
   logic        below;
   logic [15:0] cnt_inc;
   logic        cnt_hit;
   logic [31:0] dur_inc;
   logic [31:0] peak_max;

   // Settings registers; a write lands on the set_stb edge, so a sample
   // arriving on that same edge still sees the old values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg <= '0;
      end else if (set_stb) begin
         if (set_addr == BASE)           cfg.thr_hi <= set_data;
         if (set_addr == BASE + 8'd1)    cfg.thr_lo <= set_data;
         if (set_addr == BASE + 8'd2)    cfg.dwell  <= set_data[15:0];
         if (set_addr == BASE + 8'd3)    cfg.enable <= set_data[0];
      end
   end

   // Per-sample decision terms. A dwell of 0 behaves as 1. The count test is
   // ">=" rather than "==" so that lowering dwell below an in-flight count
   // fires on the next qualifying strobe instead of never.
   always_comb begin
      dwell_eff = (cfg.dwell == 16'd0) ? 16'd1 : cfg.dwell;
      dwell_one = (dwell_eff == 16'd1);
      above     = (power_in >= cfg.thr_hi);
      below     = (power_in <  cfg.thr_lo);
      cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
      cnt_hit   = ({1'b0, cnt} + 17'd1) >= {1'b0, dwell_eff};
      dur_inc   = (dur == 32'hFFFF_FFFF) ? dur : dur + 32'd1;
      peak_max  = (power_in > peak) ? power_in : peak;
   end

   // Detector FSM with registered outputs; pulses default low every cycle,
   // and dropping enable/run silently returns to IDLE without any pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         peak           <= '0;
         dur            <= '0;
         detect         <= 1'b0;
         rise_stb       <= 1'b0;
         fall_stb       <= 1'b0;
         event_stb      <= 1'b0;
         event_peak     <= '0;
         event_duration <= '0;
      end else begin
         rise_stb  <= 1'b0;
         fall_stb  <= 1'b0;
         event_stb <= 1'b0;
         if (!cfg.enable || !run) begin
            state  <= IDLE;
            cnt    <= '0;
            peak   <= '0;
            dur    <= '0;
            detect <= 1'b0;
         end else if (strobe_in) begin
            unique case (state)
               IDLE: begin
                  if (above) begin
                     cnt  <= 16'd1;
                     peak <= power_in;
                     dur  <= 32'd1;
                     if (dwell_one) begin
                        state    <= ACTIVE;
                        rise_stb <= 1'b1;
                        detect   <= 1'b1;
                     end else begin
                        state <= ARM;
                     end
                  end
               end
               ARM: begin
                  if (above) begin
                     cnt  <= cnt_inc;
                     dur  <= dur_inc;
                     peak <= peak_max;
                     if (cnt_hit) begin
                        state    <= ACTIVE;
                        rise_stb <= 1'b1;
                        detect   <= 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                     cnt   <= '0;
                     peak  <= '0;
                     dur   <= '0;
                  end
               end
               ACTIVE: begin
                  dur  <= dur_inc;
                  peak <= peak_max;
                  if (below) begin
                     if (dwell_one) begin
                        state          <= IDLE;
                        fall_stb       <= 1'b1;
                        event_stb      <= 1'b1;
                        detect         <= 1'b0;
                        event_peak     <= peak_max;
                        event_duration <= dur_inc;
                        cnt            <= '0;
                        peak           <= '0;
                        dur            <= '0;
                     end else begin
                        cnt   <= 16'd1;
                        state <= DISARM;
                     end
                  end
               end
               DISARM: begin
                  dur  <= dur_inc;
                  peak <= peak_max;
                  if (below) begin
                     cnt <= cnt_inc;
                     if (cnt_hit) begin
                        state          <= IDLE;
                        fall_stb       <= 1'b1;
                        event_stb      <= 1'b1;
                        detect         <= 1'b0;
                        event_peak     <= peak_max;
                        event_duration <= dur_inc;
                        cnt            <= '0;
                        peak           <= '0;
                        dur            <= '0;
                     end
                  end else begin
                     // Release run broken: back to ACTIVE; the next below
                     // restarts the count from 1.
                     state <= ACTIVE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign debug = {state, cnt, peak, 14'd0};

endmodule
